// File: rtl/vote_pkg.sv
// Shared definitions for the vote tally reader and the voting machine it reads.
package vote_pkg;

  localparam int NUM_CAND    = 4;
  localparam int DEF_COUNT_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    PRESS   = 3'd2,
    RELEASE = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } state_t;

  typedef logic [1:0] cand_idx_t;

endpackage

// File: rtl/vote_tally_reader_if.sv
// Bus between the tally reader (master) and the voting machine (slave).
interface vote_tally_reader_if #(
  parameter int COUNT_W = vote_pkg::DEF_COUNT_W
);

  logic               mode;
  logic               button1;
  logic               button2;
  logic               button3;
  logic               button4;
  logic [COUNT_W-1:0] led;

  modport master (
    output mode, button1, button2, button3, button4,
    input  led
  );

  modport slave (
    input  mode, button1, button2, button3, button4,
    output led
  );

endinterface

// File: rtl/vote_max4.sv
// Combinational arg-max over four unsigned counts; the lowest index wins ties.
module vote_max4
  import vote_pkg::*;
#(
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic [NUM_CAND-1:0][COUNT_W-1:0] counts,
  output cand_idx_t                        winner,
  output logic                             tie
);

  logic [COUNT_W-1:0] best;

  always_comb begin
    best   = counts[0];
    winner = '0;
    // Strict greater-than keeps the earliest index among equal maxima.
    for (int i = 1; i < NUM_CAND; i++) begin
      if (counts[i] > best) begin
        best   = counts[i];
        winner = cand_idx_t'(i);
      end
    end
    tie = 1'b0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if ((cand_idx_t'(i) != winner) && (counts[i] == best)) tie = 1'b1;
    end
  end

endmodule

// File: rtl/vote_tally_reader.sv
// Drives the voting machine into display mode, presses each candidate button
// in turn, captures the displayed counts, then reports winner and tie status.
module vote_tally_reader
  import vote_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int COUNT_W       = DEF_COUNT_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  vote_tally_reader_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  count1,
  output logic [COUNT_W-1:0]  count2,
  output logic [COUNT_W-1:0]  count3,
  output logic [COUNT_W-1:0]  count4,
  output cand_idx_t           winner,
  output logic                tie
);

  localparam int PH_MAX = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0] GAP_LAST    = PH_W'(GAP_CYCLES - 1);
  localparam cand_idx_t       LAST_CAND   = cand_idx_t'(NUM_CAND - 1);

  state_t                          state;
  state_t                          state_next;
  logic [PH_W-1:0]                 phase;
  cand_idx_t                       idx;
  logic [NUM_CAND-1:0][COUNT_W-1:0] counts;
  cand_idx_t                       max_winner;
  logic                            max_tie;

  vote_max4 #(.COUNT_W(COUNT_W)) u_max (
    .counts (counts),
    .winner (max_winner),
    .tie    (max_tie)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   if (phase == GAP_LAST) state_next = PRESS;
      PRESS:   if (phase == SETTLE_LAST) state_next = RELEASE;
      RELEASE: if (phase == GAP_LAST) state_next = (idx == LAST_CAND) ? COMPARE : PRESS;
      COMPARE: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Phase restarts on every state change, so each timed state counts from zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      phase  <= '0;
      idx    <= '0;
      counts <= '0;
      winner <= '0;
      tie    <= 1'b0;
    end else begin
      phase <= (state_next != state) ? '0 : phase + 1'b1;
      if (state == IDLE && start) idx <= '0;
      if (state == RELEASE && phase == GAP_LAST && idx != LAST_CAND) idx <= idx + 1'b1;
      if (state == PRESS && phase == SETTLE_LAST) counts[idx] <= bus.led;
      if (state == COMPARE) begin
        winner <= max_winner;
        tie    <= max_tie;
      end
    end
  end

  always_comb begin
    bus.mode    = 1'b0;
    bus.button1 = 1'b0;
    bus.button2 = 1'b0;
    bus.button3 = 1'b0;
    bus.button4 = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      SETUP, RELEASE, COMPARE: begin
        bus.mode = 1'b1;
        busy     = 1'b1;
      end
      PRESS: begin
        bus.mode = 1'b1;
        busy     = 1'b1;
        case (idx)
          2'd0:    bus.button1 = 1'b1;
          2'd1:    bus.button2 = 1'b1;
          2'd2:    bus.button3 = 1'b1;
          default: bus.button4 = 1'b1;
        endcase
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign count1 = counts[0];
  assign count2 = counts[1];
  assign count3 = counts[2];
  assign count4 = counts[3];

endmodule

// File: tb/tb_vote_tally_reader.sv
// Directed bench: models the voting machine display and checks scans, timing and reset.
module tb_vote_tally_reader;
  import vote_pkg::*;

  logic       clock;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] count1, count2, count3, count4;
  cand_idx_t  winner;
  logic       tie;
  logic [3:0] btn;
  logic [7:0] model_cnt [4];
  logic       mon_en;
  int         checks;
  int         errors;
  int         done_cnt;

  vote_tally_reader_if #(.COUNT_W(8)) bus ();

  vote_tally_reader #(.SETTLE_CYCLES(4), .GAP_CYCLES(2), .COUNT_W(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .bus    (bus.master),
    .busy   (busy),
    .done   (done),
    .count1 (count1),
    .count2 (count2),
    .count3 (count3),
    .count4 (count4),
    .winner (winner),
    .tie    (tie)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign btn = {bus.button4, bus.button3, bus.button2, bus.button1};

  // Voting machine display: shows a candidate's count while mode and its button are high.
  always_comb begin
    bus.led = '0;
    if (bus.mode) begin
      if (bus.button1) bus.led = model_cnt[0];
      if (bus.button2) bus.led = model_cnt[1];
      if (bus.button3) bus.led = model_cnt[2];
      if (bus.button4) bus.led = model_cnt[3];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clock) if (done === 1'b1) done_cnt++;

  always @(negedge clock) begin
    if (mon_en) begin
      check("one_hot_buttons", 32'($countones(btn) <= 1), 32'd1);
      check("mode_with_button", 32'((btn == 4'd0) || bus.mode), 32'd1);
    end
  end

  // Expected button vector in scan cycle c (cycle 1 follows the start edge).
  function automatic logic [3:0] exp_btn(input int c);
    int t;
    exp_btn = 4'd0;
    if (c >= 3 && c <= 26) begin
      t = c - 3;
      if (t % 6 < 4) exp_btn = 4'(1 << (t / 6));
    end
  endfunction

  task automatic wait_done(input int first_cyc, output int cyc);
    cyc = first_cyc;
    while (done !== 1'b1 && cyc < 60) begin
      check("button_seq", 32'(btn), 32'(exp_btn(cyc)));
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic run_scan(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                          input logic [7:0] c3, input int exp_w, input int exp_t);
    int cyc;
    model_cnt[0] = c0;
    model_cnt[1] = c1;
    model_cnt[2] = c2;
    model_cnt[3] = c3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("mode_after_start", 32'(bus.mode), 32'd1);
    wait_done(1, cyc);
    check("done_latency", 32'(cyc), 32'd28);
    check("count1", 32'(count1), 32'(c0));
    check("count2", 32'(count2), 32'(c1));
    check("count3", 32'(count3), 32'(c2));
    check("count4", 32'(count4), 32'(c3));
    check("winner", 32'(winner), 32'(exp_w));
    check("tie", 32'(tie), 32'(exp_t));
    check("mode_in_done", 32'(bus.mode), 32'd0);
    check("busy_in_done", 32'(busy), 32'd0);
    @(negedge clock);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int d0;
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    mon_en   = 1'b0;
    reset    = 1'b0;
    start    = 1'b0;
    for (int i = 0; i < 4; i++) model_cnt[i] = 8'd0;

    repeat (3) @(negedge clock);
    check("rst_mode", 32'(bus.mode), 32'd0);
    check("rst_buttons", 32'(btn), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count1", 32'(count1), 32'd0);
    check("rst_count4", 32'(count4), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_tie", 32'(tie), 32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clock);
    check("idle_no_start", 32'(busy), 32'd0);

    run_scan(8'd3, 8'd7, 8'd2, 8'd5, 1, 0);
    repeat (3) @(negedge clock);
    check("hold_count2", 32'(count2), 32'd7);
    check("hold_winner", 32'(winner), 32'd1);
    run_scan(8'd6, 8'd6, 8'd1, 8'd6, 0, 1);
    run_scan(8'd0, 8'd0, 8'd0, 8'd0, 0, 1);
    run_scan(8'd255, 8'd0, 8'd0, 8'd255, 0, 1);
    run_scan(8'd1, 8'd2, 8'd3, 8'd9, 3, 0);

    // Start held high: one done per scan, next scan only after an IDLE cycle.
    model_cnt[0] = 8'd3; model_cnt[1] = 8'd7; model_cnt[2] = 8'd2; model_cnt[3] = 8'd5;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clock);
    wait_done(1, cyc);
    check("held_latency1", 32'(cyc), 32'd28);
    @(negedge clock);
    check("held_idle_gap", 32'(busy), 32'd0);
    @(negedge clock);
    check("held_restart", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(1, cyc);
    check("held_latency2", 32'(cyc), 32'd28);
    @(negedge clock);
    check("held_done_count", 32'(done_cnt - d0), 32'd2);

    // Start pulsed mid-scan is ignored.
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (50) @(negedge clock);
    check("midscan_done_count", 32'(done_cnt - d0), 32'd1);
    check("midscan_idle", 32'(busy), 32'd0);

    // Reset during the third press discards the scan.
    model_cnt[0] = 8'd9; model_cnt[1] = 8'd8; model_cnt[2] = 8'd7; model_cnt[3] = 8'd6;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    while (cyc < 16) begin
      @(negedge clock);
      cyc++;
    end
    check("third_press", 32'(btn), 32'd4);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_mode", 32'(bus.mode), 32'd0);
    check("midrst_buttons", 32'(btn), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_count1", 32'(count1), 32'd0);
    check("midrst_count2", 32'(count2), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    run_scan(8'd4, 8'd1, 8'd8, 8'd2, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
